// File: rtl/mdio_responder_if.sv
// Register-side bus of the MDIO responder: the responder masters address,
// write data and strobes; the register file answers with read data.
interface mdio_responder_if;
  logic [4:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;
  logic        reg_we_o;
  logic        reg_rd_o;
  logic [15:0] reg_rdata_i;

  modport master (
    output reg_addr_o,
    output reg_wdata_o,
    output reg_we_o,
    output reg_rd_o,
    input  reg_rdata_i
  );

  modport slave (
    input  reg_addr_o,
    input  reg_wdata_o,
    input  reg_we_o,
    input  reg_rd_o,
    output reg_rdata_i
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on clk_i, decodes frames
// addressed to PHY_ADDR and turns them into single-cycle register strobes.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_LEN  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mdc_i,
  input  logic              mdio_i,
  output logic              mdio_o,
  output logic              mdio_t,
  mdio_responder_if.master  reg_bus
);

  localparam int            PW      = $clog2(PRE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA    = 3'd5;
  localparam logic [2:0] S_DATA  = 3'd6;

  logic          mdc_s1_q, mdc_s2_q, mdc_prev_q;
  logic          mdio_s1_q, mdio_s2_q;
  logic          rise_s, bit_s;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          op_hi_q, op_hi_d;
  logic          is_read_q, is_read_d;
  logic [4:0]    addr_sh_q, addr_sh_d;
  logic [15:0]   data_sh_q, data_sh_d;
  logic          cap_pend_q, cap_pend_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_t_q, mdio_t_d;
  logic [4:0]    reg_addr_q, reg_addr_d;
  logic [15:0]   reg_wdata_q, reg_wdata_d;
  logic          reg_we_q, reg_we_d;
  logic          reg_rd_q, reg_rd_d;

  // Two-flop synchronizers for MDC and MDIO plus the MDC history flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdc_s1_q   <= 1'b0;
      mdc_s2_q   <= 1'b0;
      mdc_prev_q <= 1'b0;
      mdio_s1_q  <= 1'b0;
      mdio_s2_q  <= 1'b0;
    end else begin
      mdc_s1_q   <= mdc_i;
      mdc_s2_q   <= mdc_s1_q;
      mdc_prev_q <= mdc_s2_q;
      mdio_s1_q  <= mdio_i;
      mdio_s2_q  <= mdio_s1_q;
    end
  end

  assign rise_s = mdc_s2_q & ~mdc_prev_q;
  assign bit_s  = mdio_s2_q;

  // Frame decoder: everything advances only on an MDC rise event.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_hi_d     = op_hi_q;
    is_read_d   = is_read_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_rd_d    = 1'b0;
    cap_pend_d  = reg_rd_q;

    // Read data arrives one cycle after the request strobe.
    if (cap_pend_q) begin
      data_sh_d = reg_bus.reg_rdata_i;
    end else begin
      data_sh_d = data_sh_q;
    end

    if (rise_s) begin
      case (state_q)
        S_IDLE: begin
          if (bit_s) begin
            pre_cnt_d = (pre_cnt_q == PRE_MAX) ? pre_cnt_q : pre_cnt_q + PW'(1);
          end else begin
            state_d   = (pre_cnt_q == PRE_MAX) ? S_ST : S_IDLE;
            pre_cnt_d = '0;
          end
        end
        S_ST: begin
          bit_cnt_d = 4'd0;
          state_d   = bit_s ? S_OP : S_IDLE;
        end
        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_hi_d   = bit_s;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            case ({op_hi_q, bit_s})
              2'b10: begin
                is_read_d = 1'b1;
                state_d   = S_PHYAD;
              end
              2'b01: begin
                is_read_d = 1'b0;
                state_d   = S_PHYAD;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
        S_PHYAD: begin
          addr_sh_d = {addr_sh_q[3:0], bit_s};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = 4'd0;
            state_d   = ({addr_sh_q[3:0], bit_s} == PHY_ADDR) ? S_REGAD : S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_REGAD: begin
          addr_sh_d = {addr_sh_q[3:0], bit_s};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d  = 4'd0;
            reg_addr_d = {addr_sh_q[3:0], bit_s};
            reg_rd_d   = is_read_q;
            state_d    = S_TA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_TA: begin
          if (is_read_q) begin
            if (bit_cnt_q == 4'd0) begin
              mdio_t_d  = 1'b0;
              mdio_o_d  = 1'b0;
              bit_cnt_d = 4'd1;
            end else begin
              mdio_o_d  = data_sh_q[15];
              data_sh_d = {data_sh_q[14:0], 1'b0};
              bit_cnt_d = 4'd0;
              state_d   = S_DATA;
            end
          end else begin
            if (bit_cnt_q == 4'd0) begin
              bit_cnt_d = 4'd1;
              state_d   = bit_s ? S_TA : S_IDLE;
            end else begin
              bit_cnt_d = 4'd0;
              state_d   = bit_s ? S_IDLE : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (is_read_q) begin
            if (bit_cnt_q == 4'd15) begin
              mdio_t_d  = 1'b1;
              mdio_o_d  = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = S_IDLE;
            end else begin
              mdio_o_d  = data_sh_q[15];
              data_sh_d = {data_sh_q[14:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            data_sh_d = {data_sh_q[14:0], bit_s};
            if (bit_cnt_q == 4'd15) begin
              reg_wdata_d = {data_sh_q[14:0], bit_s};
              reg_we_d    = 1'b1;
              bit_cnt_d   = 4'd0;
              state_d     = S_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d   = S_IDLE;
          pre_cnt_d = '0;
          bit_cnt_d = 4'd0;
          mdio_t_d  = 1'b1;
          mdio_o_d  = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame state, shift registers and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= 4'd0;
      op_hi_q     <= 1'b0;
      is_read_q   <= 1'b0;
      addr_sh_q   <= 5'd0;
      data_sh_q   <= 16'd0;
      cap_pend_q  <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
      reg_addr_q  <= 5'd0;
      reg_wdata_q <= 16'd0;
      reg_we_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      op_hi_q     <= op_hi_d;
      is_read_q   <= is_read_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      cap_pend_q  <= cap_pend_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_rd_q    <= reg_rd_d;
    end
  end

  assign mdio_o              = mdio_o_q;
  assign mdio_t              = mdio_t_q;
  assign reg_bus.reg_addr_o  = reg_addr_q;
  assign reg_bus.reg_wdata_o = reg_wdata_q;
  assign reg_bus.reg_we_o    = reg_we_q;
  assign reg_bus.reg_rd_o    = reg_rd_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Frame-level bench for mdio_responder: directed and random MDIO frames
// checked against a register-map model and the frame acceptance rules.
module tb_mdio_responder;
  localparam logic [4:0] PHY = 5'd1;
  localparam int         PRE = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mdc = 1'b0;
  logic mdio_in = 1'b1;
  logic mdio_o, mdio_t;

  mdio_responder_if bus ();

  mdio_responder #(.PHY_ADDR(PHY), .PRE_LEN(PRE)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .mdc_i   (mdc),
    .mdio_i  (mdio_in),
    .mdio_o  (mdio_o),
    .mdio_t  (mdio_t),
    .reg_bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // register file slave
  logic [15:0] regfile [32];
  logic init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) regfile[i] <= (16'(i) * 16'h0101) ^ 16'hC3C3;
      init_done <= 1'b1;
    end else begin
      if (bus.reg_we_o) regfile[bus.reg_addr_o] <= bus.reg_wdata_o;
      if (bus.reg_rd_o) bus.reg_rdata_i <= regfile[bus.reg_addr_o];
    end
  end

  // strobe / bus-drive monitor
  int we_cnt = 0, rd_cnt = 0, both_cnt = 0, drv_viol = 0;
  logic [4:0]  last_we_addr = 5'd0, last_rd_addr = 5'd0;
  logic [15:0] last_we_data = 16'd0;
  logic allow_drv = 1'b0;
  always @(negedge clk) begin
    if (bus.reg_we_o) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= bus.reg_addr_o;
      last_we_data <= bus.reg_wdata_o;
    end
    if (bus.reg_rd_o) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= bus.reg_addr_o;
    end
    if (bus.reg_we_o && bus.reg_rd_o) both_cnt <= both_cnt + 1;
    if (rst_n && !mdio_t && !allow_drv) drv_viol <= drv_viol + 1;
  end

  logic [15:0] model_mem [32];
  int idle_run = 0;
  logic sent_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One MDC period; returns what the pad showed just before the rise.
  task automatic slot(input logic b, output logic t_pre, output logic o_pre);
    mdio_in = b;
    sent_q.push_back(b);
    repeat (4) @(negedge clk);
    t_pre = mdio_t;
    o_pre = mdio_o;
    mdc = 1'b1;
    repeat (4) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    logic t, o;
    for (int i = n - 1; i >= 0; i--) slot(v[i], t, o);
  endtask

  task automatic reset_checks();
    check("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
    check("rst_mdio_o", {31'd0, mdio_o}, 32'd1);
    check("rst_we", {31'd0, bus.reg_we_o}, 32'd0);
    check("rst_rd", {31'd0, bus.reg_rd_o}, 32'd0);
    check("rst_addr", {27'd0, bus.reg_addr_o}, 32'd0);
    check("rst_wdata", {16'd0, bus.reg_wdata_o}, 32'd0);
  endtask

  // Sends one frame; last_f: 1=ST 2=OP 3=PHYAD 4=REGAD 5=TA 6=DATA is the last field sent.
  task automatic run_frame(input int pre, input logic st2, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] regad,
                           input logic [1:0] ta, input logic [15:0] data,
                           input bit rst_mid);
    int we0, rd0, dv0, last_f, ton, tail;
    bit accepted, exp_wr, exp_rd;
    logic t, o;
    logic [15:0] rv;
    we0 = we_cnt; rd0 = rd_cnt; dv0 = drv_viol;
    accepted = (idle_run + pre) >= PRE;
    exp_wr = 1'b0; exp_rd = 1'b0; last_f = 6;
    if (accepted) begin
      if (!st2) last_f = 1;
      else if (op != 2'b10 && op != 2'b01) last_f = 2;
      else if (phy != PHY) last_f = 3;
      else if (op == 2'b01 && ta != 2'b10) last_f = 5;
      else begin
        exp_wr = (op == 2'b01);
        exp_rd = (op == 2'b10);
      end
    end
    sent_q.delete();
    for (int i = 0; i < pre; i++) slot(1'b1, t, o);
    slot(1'b0, t, o);
    slot(st2, t, o);
    if (last_f >= 2) send_bits({14'd0, op}, 2);
    if (last_f >= 3) send_bits({11'd0, phy}, 5);
    if (last_f >= 4) send_bits({11'd0, regad}, 5);
    if (exp_rd) begin
      allow_drv = 1'b1;
      slot(1'b1, t, o);
      check("ta1_released", {31'd0, t}, 32'd1);
      slot(1'b1, t, o);
      check("ta2_drive", {30'd0, t, o}, 32'd0);
      ton = 0;
      rv = 16'd0;
      for (int i = 15; i >= 0; i--) begin
        if (rst_mid && i == 8) begin
          repeat (2) @(negedge clk);
          #2 rst_n = 1'b0;
          #1 reset_checks();
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          repeat (2) @(negedge clk);
          allow_drv = 1'b0;
          idle_run = 0;
          check("rst_no_drive", drv_viol - dv0, 32'd0);
          return;
        end
        slot(1'b1, t, o);
        rv[i] = o;
        if (t == 1'b0) ton++;
      end
      repeat (3) @(negedge clk);
      check("rel_after_d0", {31'd0, mdio_t}, 32'd1);
      allow_drv = 1'b0;
      check("rd_data", {16'd0, rv}, {16'd0, model_mem[regad]});
      check("drive_slots", ton, 32'd16);
    end else begin
      if (last_f >= 5) send_bits({14'd0, ta}, 2);
      if (last_f >= 6) send_bits(data, 16);
    end
    if (accepted) idle_run = 0;
    else begin
      tail = 0;
      while (tail < sent_q.size() && sent_q[sent_q.size() - 1 - tail] == 1'b1) tail++;
      idle_run = tail;
    end
    repeat (3) @(negedge clk);
    check("we_pulses", we_cnt - we0, {31'd0, exp_wr});
    check("rd_pulses", rd_cnt - rd0, {31'd0, exp_rd});
    check("no_stray_drive", drv_viol - dv0, 32'd0);
    if (exp_wr) begin
      check("we_addr", {27'd0, last_we_addr}, {27'd0, regad});
      check("we_data", {16'd0, last_we_data}, {16'd0, data});
      model_mem[regad] = data;
    end
    if (exp_rd) check("rd_addr", {27'd0, last_rd_addr}, {27'd0, regad});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [1:0] op, ta;
    logic [4:0] phy;
    int r;
    for (int i = 0; i < 32; i++) model_mem[i] = (16'(i) * 16'h0101) ^ 16'hC3C3;
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(32, 1'b1, 2'b01, 5'd1, 5'd4, 2'b10, 16'hBEEF, 1'b0);
    run_frame(32, 1'b1, 2'b01, 5'd1, 5'd3, 2'b10, 16'h1234, 1'b0);
    run_frame(32, 1'b1, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, 1'b0);
    run_frame(32, 1'b1, 2'b10, 5'd2, 5'd3, 2'b11, 16'h0000, 1'b0);
    run_frame(31, 1'b1, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, 1'b0);
    run_frame(32, 1'b1, 2'b10, 5'd1, 5'd3, 2'b11, 16'h0000, 1'b0);
    run_frame(32, 1'b1, 2'b01, 5'd1, 5'd5, 2'b11, 16'hAAAA, 1'b0);
    run_frame(32, 1'b1, 2'b01, 5'd1, 5'd5, 2'b10, 16'h5555, 1'b0);
    run_frame(32, 1'b1, 2'b10, 5'd1, 5'd5, 2'b11, 16'h0000, 1'b0);
    run_frame(32, 1'b1, 2'b11, 5'd1, 5'd4, 2'b10, 16'h0F0F, 1'b0);
    run_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 1'b0);
    run_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 1'b1);
    run_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 2'b11, 16'h0000, 1'b0);

    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b00;
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : PHY;
      r = $urandom_range(0, 3);
      ta = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : 2'b10;
      run_frame($urandom_range(30, 34), ($urandom_range(0, 7) != 0), op, phy,
                5'($urandom_range(0, 31)), ta, 16'($urandom), 1'b0);
    end

    check("we_rd_overlap", both_cnt, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
